// File: rtl/register_file_sb.sv
// rtl/register_file_sb.sv - register file with per-register busy scoreboard
//
// Two combinational read ports, one write port, and one claim port.
// A claim marks a destination busy until a write to it completes.
//
// Parameters:
//   DATA_W   register width
//   ADDR_W   address width, DEPTH = 2**ADDR_W
//   BYPASS   1 = forward same-cycle write data and busy-clear to the read ports
//   ZERO_REG 1 = register 0 is hard zero and never busy
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   wr_en, wr_addr, wr_data    write port (also completes a pending claim)
//   claim_en, claim_addr       marks a register busy
//   rd_addr1/2 -> rd_data1/2   read data
//   busy1/2                    read source has a pending result
//   busy_count, any_busy       busy population and its non-zero flag
module register_file_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 4,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              claim_en,
    input  logic [ADDR_W-1:0] claim_addr,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              busy1,
    output logic              busy2,
    output logic [ADDR_W:0]   busy_count,
    output logic              any_busy
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [ADDR_W:0]   count_q;

    logic wr_eff;
    logic claim_eff;
    logic new_claim;
    logic clear_busy;

    // Accesses to register 0 are dropped entirely when it is hard-wired to zero.
    assign wr_eff    = wr_en    && !((ZERO_REG != 0) && (wr_addr == '0));
    assign claim_eff = claim_en && !((ZERO_REG != 0) && (claim_addr == '0));

    // Count only real transitions of the busy vector, so re-claims and
    // writes to idle registers leave the count alone. A claim and write to
    // the same register keeps it busy (claim wins), hence no clear there.
    assign new_claim  = claim_eff && !busy_q[claim_addr];
    assign clear_busy = wr_eff && busy_q[wr_addr] && !(claim_eff && (claim_addr == wr_addr));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            if (wr_eff) begin
                regs[wr_addr] <= wr_data;
            end
            if (clear_busy) begin
                busy_q[wr_addr] <= 1'b0;
            end
            if (claim_eff) begin
                busy_q[claim_addr] <= 1'b1;
            end
            count_q <= count_q + {{ADDR_W{1'b0}}, new_claim} - {{ADDR_W{1'b0}}, clear_busy};
        end
    end

    logic zero1, zero2;
    logic fwd1, fwd2;

    assign zero1 = (ZERO_REG != 0) && (rd_addr1 == '0);
    assign zero2 = (ZERO_REG != 0) && (rd_addr2 == '0);
    assign fwd1  = (BYPASS != 0) && wr_en && (wr_addr == rd_addr1);
    assign fwd2  = (BYPASS != 0) && wr_en && (wr_addr == rd_addr2);

    assign rd_data1 = zero1 ? '0 : (fwd1 ? wr_data : regs[rd_addr1]);
    assign rd_data2 = zero2 ? '0 : (fwd2 ? wr_data : regs[rd_addr2]);

    // A same-cycle claim is not visible here; a same-cycle write hides busy.
    assign busy1 = !zero1 && !fwd1 && busy_q[rd_addr1];
    assign busy2 = !zero2 && !fwd2 && busy_q[rd_addr2];

    assign busy_count = count_q;
    assign any_busy   = (count_q != '0);

endmodule

// File: tb/tb_register_file_sb.sv
// tb/tb_register_file_sb.sv - directed self-checking bench for register_file_sb
module tb_register_file_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic        claim_en;
    logic [3:0]  claim_addr;
    logic [3:0]  rd_addr1;
    logic [3:0]  rd_addr2;

    // a: defaults (bypass), b: no bypass, c: hard-zero register 0
    logic [31:0] a_rd1, a_rd2, b_rd1, b_rd2, c_rd1, c_rd2;
    logic        a_b1, a_b2, b_b1, b_b2, c_b1, c_b2;
    logic [4:0]  a_cnt, b_cnt, c_cnt;
    logic        a_any, b_any, c_any;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    register_file_sb u_a (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .claim_en(claim_en), .claim_addr(claim_addr), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(a_rd1), .rd_data2(a_rd2), .busy1(a_b1), .busy2(a_b2),
        .busy_count(a_cnt), .any_busy(a_any)
    );

    register_file_sb #(.BYPASS(0)) u_b (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .claim_en(claim_en), .claim_addr(claim_addr), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(b_rd1), .rd_data2(b_rd2), .busy1(b_b1), .busy2(b_b2),
        .busy_count(b_cnt), .any_busy(b_any)
    );

    register_file_sb #(.ZERO_REG(1)) u_c (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .claim_en(claim_en), .claim_addr(claim_addr), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(c_rd1), .rd_data2(c_rd2), .busy1(c_b1), .busy2(c_b2),
        .busy_count(c_cnt), .any_busy(c_any)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one edge, then settle away from it before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en    = 1'b0;
        claim_en = 1'b0;
        rst      = 1'b0;
    endtask

    task automatic do_write(input logic [3:0] addr, input logic [31:0] data);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
    endtask

    task automatic do_claim(input logic [3:0] addr);
        claim_en   = 1'b1;
        claim_addr = addr;
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b1; wr_addr = 4'd1; wr_data = 32'hFFFF_FFFF;
        claim_en = 1'b1; claim_addr = 4'd1; rd_addr1 = 4'd1; rd_addr2 = 4'd0;
        #2;
        tick();
        idle();
        #1;
        // Reset state, with write/claim ignored during reset
        check("rst_rd1",   a_rd1, 32'h0);
        check("rst_busy1", 32'(a_b1), 32'h0);
        check("rst_cnt",   32'(a_cnt), 32'h0);
        check("rst_any",   32'(a_any), 32'h0);

        // Write then read R3
        do_write(4'd3, 32'hDEAD_BEEF);
        tick();
        idle();
        rd_addr1 = 4'd3;
        #1;
        check("r3_data",  a_rd1, 32'hDEAD_BEEF);
        check("r3_busy",  32'(a_b1), 32'h0);

        // Same-cycle forwarding vs none
        rd_addr2 = 4'd5;
        do_write(4'd5, 32'h1234);
        #1;
        check("byp_on_r5",  a_rd2, 32'h1234);
        check("byp_off_r5", b_rd2, 32'h0);
        tick();
        idle();
        #1;
        check("byp_off_r5_next", b_rd2, 32'h1234);

        // Claim R7, complete it five cycles later
        do_claim(4'd7);
        rd_addr1 = 4'd7;
        #1;
        check("claim_not_same_cycle", 32'(a_b1), 32'h0);
        tick();
        idle();
        #1;
        check("r7_busy", 32'(a_b1), 32'h1);
        check("r7_cnt",  32'(a_cnt), 32'h1);
        check("r7_any",  32'(a_any), 32'h1);
        repeat (4) tick();
        do_write(4'd7, 32'h55);
        #1;
        check("r7_busy_fwd",   32'(a_b1), 32'h0);
        check("r7_busy_nofwd", 32'(b_b1), 32'h1);
        check("r7_data_fwd",   a_rd1, 32'h55);
        tick();
        idle();
        #1;
        check("r7_busy_done", 32'(a_b1), 32'h0);
        check("r7_cnt_done",  32'(a_cnt), 32'h0);
        check("r7_any_done",  32'(a_any), 32'h0);

        // Claim and write same register: claim wins, data written
        do_claim(4'd2);
        do_write(4'd2, 32'hA);
        tick();
        idle();
        rd_addr1 = 4'd2;
        #1;
        check("r2_data", a_rd1, 32'hA);
        check("r2_busy", 32'(a_b1), 32'h1);
        check("r2_cnt",  32'(a_cnt), 32'h1);

        // Claim R6, then claim R4 while completing R6
        do_claim(4'd6);
        tick();
        idle();
        #1;
        check("r6_cnt", 32'(a_cnt), 32'h2);
        do_claim(4'd4);
        do_write(4'd6, 32'h66);
        tick();
        idle();
        rd_addr1 = 4'd4;
        rd_addr2 = 4'd6;
        #1;
        check("r4_busy",    32'(a_b1), 32'h1);
        check("r6_busy",    32'(a_b2), 32'h0);
        check("r4r6_cnt",   32'(a_cnt), 32'h2);

        // Re-claim a busy register and write an idle one: count holds
        do_claim(4'd4);
        do_write(4'd3, 32'h1);
        tick();
        idle();
        #1;
        check("reclaim_cnt", 32'(a_cnt), 32'h2);

        // Both ports on one address agree
        rd_addr1 = 4'd3;
        rd_addr2 = 4'd3;
        #1;
        check("dual_rd1", a_rd1, 32'h1);
        check("dual_rd2", a_rd2, 32'h1);

        // Claim R1, R3 (R2, R4 already busy), then reset with a write pending
        do_claim(4'd1);
        tick();
        do_claim(4'd3);
        tick();
        idle();
        #1;
        check("pre_rst_cnt", 32'(a_cnt), 32'h4);
        rst = 1'b1;
        do_write(4'd9, 32'h9999);
        do_claim(4'd8);
        tick();
        idle();
        rd_addr1 = 4'd3;
        rd_addr2 = 4'd7;
        #1;
        check("mid_rst_cnt", 32'(a_cnt), 32'h0);
        check("mid_rst_any", 32'(a_any), 32'h0);
        check("mid_rst_r3",  a_rd1, 32'h0);
        check("mid_rst_r7",  a_rd2, 32'h0);
        rd_addr2 = 4'd9;
        #1;
        check("mid_rst_r9",  a_rd2, 32'h0);

        // Hard-zero register 0 versus an ordinary register 0
        rd_addr1 = 4'd0;
        do_write(4'd0, 32'hFFFF);
        do_claim(4'd0);
        #1;
        check("z0_byp_data", c_rd1, 32'h0);
        tick();
        idle();
        #1;
        check("z0_data",   c_rd1, 32'h0);
        check("z0_busy",   32'(c_b1), 32'h0);
        check("z0_cnt",    32'(c_cnt), 32'h0);
        check("plain_r0",  a_rd1, 32'hFFFF);
        check("plain_b0",  32'(a_b1), 32'h1);

        for (int i = 1; i < 16; i++) begin
            do_claim(4'(i));
            tick();
        end
        idle();
        #1;
        check("z_all_cnt",  32'(c_cnt), 32'd15);
        check("z_all_any",  32'(c_any), 32'h1);
        check("plain_full", 32'(a_cnt), 32'd16);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
